// File: rtl/trace_tx.sv
// trace_tx: serialises 16-bit trace halfwords LSB first onto a DDR trace port of 1, 2 or 4 lanes.
// Defining TRACE_TX_PERIODIC_SYNC_EN adds a full sync after every SYNC_INTERVAL completed frames.
module trace_tx #(
  parameter int BUSWIDTH      = 4,
  parameter int SYNC_INTERVAL = 16
) (
  input  logic                traceClkin,
  input  logic                rst,
  input  logic [2:0]          width,
  input  logic [15:0]         wrWd,
  input  logic                wrValid,
  output logic                wrReady,
  input  logic                syncReq,
  output logic [BUSWIDTH-1:0] traceDouta,
  output logic [BUSWIDTH-1:0] traceDoutb,
  output logic                syncActive,
  output logic                frameDone
);

  localparam logic [15:0] SYNC_HI = 16'hFFFF;
  localparam logic [15:0] SYNC_LO = 16'h7FFF;

  typedef enum logic [1:0] {SYNC, DATA, BAD} state_e;

  if (BUSWIDTH < 1 || SYNC_INTERVAL < 1) begin : g_param_check
    $error("trace_tx: BUSWIDTH and SYNC_INTERVAL must be at least 1");
  end

  function automatic logic width_ok(input logic [2:0] w);
    return ((w == 3'd1) || (w == 3'd2) || (w == 3'd4)) && (int'(w) <= BUSWIDTH);
  endfunction

  // Low w bits of hw, zero-extended so unused lanes stay 0.
  function automatic logic [BUSWIDTH-1:0] lane(input logic [15:0] hw, input logic [2:0] w);
    logic [15:0] mask;
    mask = (16'd1 << w) - 16'd1;
    return BUSWIDTH'(hw & mask);
  endfunction

  function automatic logic [2:0] last_beat(input logic [2:0] w);
    case (w)
      3'd1:    return 3'd7;
      3'd2:    return 3'd3;
      default: return 3'd1;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic                sync_half_q, sync_half_d;
  logic [2:0]          beat_q, beat_d;
  logic [15:0]         shift_q, shift_d;
  logic [2:0]          width_q, width_d;
  logic [BUSWIDTH-1:0] douta_q, douta_d;
  logic [BUSWIDTH-1:0] doutb_q, doutb_d;
  logic                sync_active_q, sync_active_d;
  logic                frame_done_q, frame_done_d;
  logic [2:0]          frame_cnt_q, frame_cnt_d;
  logic                sync_pending_q, sync_pending_d;
`ifdef TRACE_TX_PERIODIC_SYNC_EN
  localparam int IW = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;
  logic [IW-1:0]       interval_q, interval_d;
`endif

  logic        boundary;
  logic        sync_due;
  logic        wr_fire;
  logic        do_load;
  logic [15:0] load_hw;

  // beat_q counts beats still to show after the one on the pins; 0 marks a halfword boundary.
  assign boundary = (beat_q == 3'd0);
  assign sync_due = sync_pending_q || syncReq;
  assign wrReady  = (state_q == DATA) && boundary && !sync_pending_q && !syncReq && width_ok(width);
  assign wr_fire  = wrValid && wrReady;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d        = state_q;
    sync_half_d    = sync_half_q;
    beat_d         = beat_q;
    shift_d        = shift_q;
    width_d        = width_q;
    douta_d        = douta_q;
    doutb_d        = doutb_q;
    sync_active_d  = sync_active_q;
    frame_done_d   = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    sync_pending_d = sync_pending_q;
    do_load        = 1'b0;
    load_hw        = SYNC_LO;
`ifdef TRACE_TX_PERIODIC_SYNC_EN
    interval_d     = interval_q;
`endif

    if (syncReq && state_q == DATA) sync_pending_d = 1'b1;

    case (state_q)
      BAD: begin
        douta_d       = '0;
        doutb_d       = '0;
        sync_active_d = 1'b0;
        if (width_ok(width)) begin
          state_d     = SYNC;
          sync_half_d = 1'b0;
          beat_d      = 3'd0;
        end
      end
      default: begin
        if (!boundary) begin
          douta_d = lane(shift_q, width_q);
          doutb_d = lane(shift_q >> width_q, width_q);
          shift_d = shift_q >> {width_q, 1'b0};
          beat_d  = beat_q - 3'd1;
        end else if (!width_ok(width)) begin
          state_d        = BAD;
          douta_d        = '0;
          doutb_d        = '0;
          sync_active_d  = 1'b0;
          beat_d         = 3'd0;
          frame_cnt_d    = 3'd0;
          sync_pending_d = 1'b0;
        end else if (state_q == SYNC) begin
          do_load       = 1'b1;
          load_hw       = sync_half_q ? SYNC_LO : SYNC_HI;
          sync_active_d = 1'b1;
          sync_half_d   = !sync_half_q;
          if (sync_half_q) state_d = DATA;
        end else if (sync_due) begin
          // A pending sync wins over data and drops any partial frame.
          do_load        = 1'b1;
          load_hw        = SYNC_HI;
          sync_active_d  = 1'b1;
          state_d        = SYNC;
          sync_half_d    = 1'b1;
          frame_cnt_d    = 3'd0;
          sync_pending_d = 1'b0;
        end else if (wr_fire) begin
          do_load       = 1'b1;
          load_hw       = wrWd;
          sync_active_d = 1'b0;
          frame_cnt_d   = frame_cnt_q + 3'd1;
          if (frame_cnt_q == 3'd7) begin
            frame_done_d = 1'b1;
`ifdef TRACE_TX_PERIODIC_SYNC_EN
            if (interval_q == IW'(SYNC_INTERVAL - 1)) begin
              interval_d     = '0;
              sync_pending_d = 1'b1;
            end else begin
              interval_d = interval_q + 1'b1;
            end
`endif
          end
        end else begin
          do_load       = 1'b1;
          load_hw       = SYNC_LO;
          sync_active_d = 1'b0;
        end
      end
    endcase

    // The width is sampled only here, so a halfword in flight finishes at its own width.
    if (do_load) begin
      width_d = width;
      douta_d = lane(load_hw, width);
      doutb_d = lane(load_hw >> width, width);
      shift_d = load_hw >> {width, 1'b0};
      beat_d  = last_beat(width);
    end
  end

  // NOTE: reset is synchronous to traceClkin; it is sampled only on the clock edge.
  always_ff @(posedge traceClkin) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q        <= SYNC;
      sync_half_q    <= 1'b0;
      beat_q         <= 3'd0;
      shift_q        <= '0;
      width_q        <= 3'd4;
      douta_q        <= '0;
      doutb_q        <= '0;
      sync_active_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_cnt_q    <= 3'd0;
      sync_pending_q <= 1'b0;
`ifdef TRACE_TX_PERIODIC_SYNC_EN
      interval_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      sync_half_q    <= sync_half_d;
      beat_q         <= beat_d;
      shift_q        <= shift_d;
      width_q        <= width_d;
      douta_q        <= douta_d;
      doutb_q        <= doutb_d;
      sync_active_q  <= sync_active_d;
      frame_done_q   <= frame_done_d;
      frame_cnt_q    <= frame_cnt_d;
      sync_pending_q <= sync_pending_d;
`ifdef TRACE_TX_PERIODIC_SYNC_EN
      interval_q     <= interval_d;
`endif
    end
  end

  assign traceDouta = douta_q;
  assign traceDoutb = doutb_q;
  assign syncActive = sync_active_q;
  assign frameDone  = frame_done_q;

endmodule

// File: tb/tb_trace_tx.sv
// tb_trace_tx: randomized and directed stimulus for trace_tx, checked against a halfword-level model.
module tb_trace_tx;

  localparam int BW = 4;
  localparam int SI = 2;
  localparam int M_SYNC = 0;
  localparam int M_DATA = 1;
  localparam int M_BAD  = 2;

  logic          traceClkin = 1'b0;
  logic          rst        = 1'b1;
  logic [2:0]    width      = 3'd4;
  logic [15:0]   wrWd       = 16'h0;
  logic          wrValid    = 1'b0;
  logic          syncReq    = 1'b0;
  logic          wrReady;
  logic [BW-1:0] traceDouta;
  logic [BW-1:0] traceDoutb;
  logic          syncActive;
  logic          frameDone;

  trace_tx #(.BUSWIDTH(BW), .SYNC_INTERVAL(SI)) dut (
    .traceClkin (traceClkin),
    .rst        (rst),
    .width      (width),
    .wrWd       (wrWd),
    .wrValid    (wrValid),
    .wrReady    (wrReady),
    .syncReq    (syncReq),
    .traceDouta (traceDouta),
    .traceDoutb (traceDoutb),
    .syncActive (syncActive),
    .frameDone  (frameDone)
  );

  always #5 traceClkin = ~traceClkin;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the halfword on the pins plus which beat of it is showing.
  int m_mode, m_sync_step, m_hw, m_w, m_beat, m_fcnt, m_frames;
  bit m_start, m_pending, m_sa, m_zero;
  bit e_ready, e_done, e_acc;
  int e_a, e_b;

  logic            obs_ready;
  logic [2*BW+2:0] obs, exp_v;  // {wrReady, a, b, syncActive, frameDone}

  function automatic bit w_ok(input int w);
    return (w == 1) || (w == 2) || (w == 4);
  endfunction

  function automatic bit model_boundary();
    return m_start || (m_mode != M_BAD && m_beat == 8 / m_w - 1);
  endfunction

  task automatic model_reset();
    m_mode = M_SYNC; m_sync_step = 0; m_start = 1; m_pending = 0;
    m_fcnt = 0; m_frames = 0; m_sa = 0; m_zero = 1; m_hw = 0; m_w = 4; m_beat = 0;
    e_done = 0; e_acc = 0; e_a = 0; e_b = 0;
  endtask

  task automatic model_step(input int w, input bit v, input int d, input bit s);
    bit bnd;
    bnd     = model_boundary();
    e_ready = (m_mode == M_DATA) && bnd && !m_pending && !s && w_ok(w);
    e_acc   = v && e_ready;
    e_done  = 0;
    if (s && m_mode == M_DATA) m_pending = 1;
    if (m_mode == M_BAD) begin
      m_zero = 1; m_sa = 0;
      if (w_ok(w)) begin m_mode = M_SYNC; m_sync_step = 0; m_start = 1; end
    end else if (!bnd) begin
      m_beat++;
    end else if (!w_ok(w)) begin
      m_mode = M_BAD; m_zero = 1; m_sa = 0; m_fcnt = 0; m_pending = 0; m_start = 0;
    end else begin
      m_start = 0; m_zero = 0; m_w = w; m_beat = 0;
      if (m_mode == M_SYNC) begin
        m_hw = (m_sync_step == 1) ? 'h7FFF : 'hFFFF;
        m_sa = 1;
        if (m_sync_step == 1) m_mode = M_DATA;
        m_sync_step = 1 - m_sync_step;
      end else if (m_pending) begin
        m_hw = 'hFFFF; m_sa = 1; m_mode = M_SYNC; m_sync_step = 1; m_fcnt = 0; m_pending = 0;
      end else if (e_acc) begin
        m_hw = d; m_sa = 0; m_fcnt++;
        if (m_fcnt == 8) begin
          m_fcnt = 0; e_done = 1; m_frames++;
`ifdef TRACE_TX_PERIODIC_SYNC_EN
          if (m_frames % SI == 0) m_pending = 1;
`endif
        end
      end else begin
        m_hw = 'h7FFF; m_sa = 0;
      end
    end
    if (m_zero) begin
      e_a = 0; e_b = 0;
    end else begin
      e_a = (m_hw >> (2 * m_w * m_beat)) % (1 << m_w);
      e_b = (m_hw >> (2 * m_w * m_beat + m_w)) % (1 << m_w);
    end
  endtask

  // One clock: drive inputs, sample wrReady mid-cycle, advance model and DUT, sample pins after the edge.
  task automatic step(input bit r, input int w, input bit v, input int d, input bit s);
    rst = r; width = 3'(w); wrValid = v; wrWd = 16'(d); syncReq = s;
    @(negedge traceClkin);
    obs_ready = wrReady;
    if (r) begin
      e_ready = (m_mode == M_DATA) && model_boundary() && !m_pending && !s && w_ok(w);
      e_acc   = 0;
      model_reset();
    end else begin
      model_step(w, v, d, s);
    end
    @(posedge traceClkin);
    #1;
    obs   = {obs_ready, traceDouta, traceDoutb, syncActive, frameDone};
    exp_v = {e_ready, BW'(e_a), BW'(e_b), m_sa, e_done};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 4, 1, 'h1234, 0);
      n_vec++;
      if (obs !== exp_v || obs !== '0) begin
        n_bad++; $display("FAIL reset[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_sync_after_reset();
    logic [BW-1:0] tb_b [4];
    tb_b = '{4'hF, 4'hF, 4'hF, 4'h7};
    for (int i = 0; i < 4; i++) begin
      step(0, 4, 0, 0, 0);
      n_vec++;
      if (obs !== exp_v || traceDouta !== 4'hF || traceDoutb !== tb_b[i] || syncActive !== 1'b1) begin
        n_bad++; $display("FAIL sync_after_reset[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_data_w4();
    bit sent = 0;
    for (int i = 0; i < 6 && !sent; i++) begin
      step(0, 4, 1, 'h1234, 0);
      n_vec++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL data_w4: got %h want %h", obs, exp_v); end
      if (e_acc) begin
        sent = 1;
        n_vec++;
        if ({traceDouta, traceDoutb} !== {4'h4, 4'h3}) begin
          n_bad++; $display("FAIL data_w4 beat0: got %h%h want 43", traceDouta, traceDoutb);
        end
      end
    end
    n_vec++;
    if (!sent) begin n_bad++; $display("FAIL data_w4 accept: got none want 1"); end
    step(0, 4, 0, 0, 0);
    n_vec++;
    if (obs !== exp_v || {traceDouta, traceDoutb} !== {4'h2, 4'h1}) begin
      n_bad++; $display("FAIL data_w4 beat1: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_idle();
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 4, 0, 0, 0);
      pulses += int'(obs_ready);
      n_vec++;
      if (obs !== exp_v || traceDouta !== 4'hF || traceDoutb !== ((i % 2 == 0) ? 4'hF : 4'h7)) begin
        n_bad++; $display("FAIL idle[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
    n_vec++;
    if (pulses !== 4) begin n_bad++; $display("FAIL idle ready pulses: got %0d want 4", pulses); end
  endtask

  task automatic test_width1();
    bit sent = 0;
    for (int i = 0; i < 10 && !sent; i++) begin
      step(0, 1, 1, 'h0001, 0);
      n_vec++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL width1 load: got %h want %h", obs, exp_v); end
      sent = e_acc;
    end
    n_vec++;
    if (!sent || traceDouta !== 4'h1 || traceDoutb !== 4'h0) begin
      n_bad++; $display("FAIL width1 beat0: got %h/%h want 1/0", traceDouta, traceDoutb);
    end
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 0, 0);
      n_vec++;
      if (obs !== exp_v || traceDouta !== 4'h0 || traceDoutb !== 4'h0) begin
        n_bad++; $display("FAIL width1 beat%0d: got %h want %h", i + 1, obs, exp_v);
      end
    end
  endtask

  task automatic test_sync_req();
    int words = 0;
    int dones = 0;
    for (int i = 0; i < 40 && words < 3; i++) begin
      step(0, 4, 1, int'($urandom_range(0, 65535)), 0);
      words += int'(e_acc);
      n_vec++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL sync_req pre: got %h want %h", obs, exp_v); end
    end
    for (int i = 0; i < 10 && !(model_boundary() && m_mode == M_DATA); i++) begin
      step(0, 4, 0, 0, 0);
      n_vec++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL sync_req align: got %h want %h", obs, exp_v); end
    end
    step(0, 4, 1, 'hABCD, 1);
    n_vec++;
    if (obs !== exp_v || obs_ready !== 1'b0 || syncActive !== 1'b1) begin
      n_bad++; $display("FAIL sync_req hit: got %h want %h", obs, exp_v);
    end
    words = 0;
    for (int i = 0; i < 60 && words < 8; i++) begin
      step(0, 4, 1, int'($urandom_range(0, 65535)), 0);
      words += int'(e_acc);
      dones += int'(frameDone);
      n_vec++;
      if (obs !== exp_v || (e_acc && frameDone !== (words == 8))) begin
        n_bad++; $display("FAIL sync_req frame: got %h want %h", obs, exp_v);
      end
    end
    n_vec++;
    if (words != 8 || dones != 1) begin
      n_bad++; $display("FAIL sync_req frameDone count: got %0d/%0d want 8/1", words, dones);
    end
  endtask

  task automatic test_stream16();
    int words = 0;
    int rises = 0;
    int rise_at = -1;
    int dones = 0;
    int want_rises;
    bit prev_sa;
    step(1, 4, 0, 0, 0);
    step(1, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 4, 0, 0, 0);
    prev_sa = syncActive;
    for (int i = 0; i < 100 && (words < 16 || i < 60); i++) begin
      step(0, 4, words < 16, int'($urandom_range(0, 65535)), 0);
      words += int'(e_acc);
      dones += int'(frameDone);
      if (syncActive && !prev_sa) begin rises++; rise_at = words; end
      prev_sa = syncActive;
      n_vec++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL stream16: got %h want %h", obs, exp_v); end
    end
`ifdef TRACE_TX_PERIODIC_SYNC_EN
    want_rises = 1;
`else
    want_rises = 0;
`endif
    n_vec++;
    if (words != 16 || dones != 2 || rises != want_rises || (rises == 1 && rise_at != 16)) begin
      n_bad++;
      $display("FAIL stream16 summary: words %0d dones %0d syncs %0d at %0d want 16 2 %0d at 16",
               words, dones, rises, rise_at, want_rises);
    end
  endtask

  task automatic test_bad_width();
    bit seen_sync = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 3, 1, 'h5555, 0);
      n_vec++;
      if (obs !== exp_v || (i >= 8 && obs !== '0)) begin
        n_bad++; $display("FAIL bad_width[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
    for (int i = 0; i < 12; i++) begin
      step(0, 2, 0, 0, 0);
      seen_sync |= syncActive;
      n_vec++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL bad_recover[%0d]: got %h want %h", i, obs, exp_v); end
    end
    n_vec++;
    if (!seen_sync) begin n_bad++; $display("FAIL bad_recover sync: got 0 want 1"); end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 8 && !e_acc; i++) step(0, 2, 1, 'h9C3A, 0);
    step(0, 2, 0, 0, 0);
    step(1, 2, 1, 'h1111, 0);
    n_vec++;
    if (obs !== exp_v || {traceDouta, traceDoutb, syncActive, frameDone} !== '0) begin
      n_bad++; $display("FAIL rst_mid: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 2))
        0: w = 1;
        1: w = 2;
        default: w = 4;
      endcase
      if ($urandom_range(0, 40) == 0) w = 3 + 2 * int'($urandom_range(0, 2));
      step($urandom_range(0, 150) == 0, w, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 65535)), $urandom_range(0, 15) == 0);
      n_vec++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp_v); end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge traceClkin);
    #1;
    test_reset();
    test_sync_after_reset();
    test_data_w4();
    test_idle();
    test_width1();
    test_sync_req();
    test_stream16();
    test_bad_width();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
